// File: rtl/sysarr_ctrl.sv
// Operand/result buffer controller for a 3x3 systolic array: skews A/B into the array and captures C.
// Optional completed-run counter is built only when SYSARR_CTRL_PERF_EN is defined.
module sysarr_ctrl #(
    parameter int RES_LAT = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        start,
    output logic [31:0] a_row0,
    output logic [31:0] a_row1,
    output logic [31:0] a_row2,
    output logic [31:0] b_col0,
    output logic [31:0] b_col1,
    output logic [31:0] b_col2,
    input  logic [31:0] res0,
    input  logic [31:0] res1,
    input  logic [31:0] res2,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] perf_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'(RES_LAT + 4);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  t;
    logic [31:0] a_mem [9];
    logic [31:0] b_mem [9];
    logic [31:0] c_mem [9];
    logic [31:0] res [3];
    logic [31:0] a_feed [3];
    logic [31:0] b_feed [3];

    assign res[0] = res0;
    assign res[1] = res1;
    assign res[2] = res2;

    // t only counts inside RUN, so entering RUN always starts from step 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            t     <= '0;
        end else begin
            state <= state_nxt;
            t     <= (state == RUN) ? t + 5'd1 : 5'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (t == LAST_STEP) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand writes are only legal while idle; anything else is dropped and flagged
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
            err <= 1'b0;
        end else if (wr_en) begin
            if (state != IDLE || wr_addr > 4'd8) begin
                err <= 1'b1;
            end else if (wr_sel) begin
                b_mem[wr_addr] <= wr_data;
            end else begin
                a_mem[wr_addr] <= wr_data;
            end
        end
    end

    // Lane k carries C[r][k] at step RES_LAT + r + k
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) c_mem[i] <= '0;
        end else if (state == RUN) begin
            for (int k = 0; k < 3; k++) begin
                for (int r = 0; r < 3; r++) begin
                    if (t == 5'(RES_LAT + r + k)) c_mem[3*r + k] <= res[k];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            a_feed[i] = '0;
            b_feed[i] = '0;
            if (state == RUN && t <= 5'd6) begin
                for (int k = 0; k < 3; k++) begin
                    if (int'(t) == i + k) begin
                        a_feed[i] = a_mem[3*i + k];
                        b_feed[i] = b_mem[3*k + i];
                    end
                end
            end
        end
    end

    assign a_row0  = a_feed[0];
    assign a_row1  = a_feed[1];
    assign a_row2  = a_feed[2];
    assign b_col0  = b_feed[0];
    assign b_col1  = b_feed[1];
    assign b_col2  = b_feed[2];
    assign rd_data = (rd_addr <= 4'd8) ? c_mem[rd_addr] : 32'h0000_0000;

`ifdef SYSARR_CTRL_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else if (state == DONE) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_count = perf_q;
`else
    assign perf_count = 16'h0000;
`endif

endmodule
